qspi_flash_ctrl: RTL and testbench



---
 rtl/qspi_flash_ctrl_pkg.sv | 30 +++
 rtl/qspi_flash_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_qspi_flash_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_flash_ctrl_pkg.sv
// Shared definitions for the quad-SPI flash read controller.
// Contents: Quad Output Fast Read opcode, SCK-cycle phase lengths, FSM state enum,
//           and a helper returning the last SCK index of a serial phase.
package qspi_flash_ctrl_pkg;

  localparam logic [7:0] OPCODE_QOFR = 8'h6B;
  localparam int         CMD_SCK     = 8;
  localparam int         ADDR_SCK    = 24;
  localparam int         DUMMY_SCK   = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    STALLED,
    DESELECT
  } state_e;

  // Index of the final SCK cycle of a serial phase (counter compares against this).
  function automatic logic [4:0] phase_last(state_e s);
    case (s)
      CMD:     return 5'(CMD_SCK - 1);
      ADDR:    return 5'(ADDR_SCK - 1);
      default: return 5'(DUMMY_SCK - 1);
    endcase
  endfunction

endpackage

// File: rtl/qspi_flash_ctrl.sv
// Quad-SPI read-only flash controller: issues 0x6B + 24-bit address + 8 dummy SCKs, then
// streams nibbles into DATA_WIDTH_BYTES-wide words (byte 0 = first byte, in [7:0]).
// Ports: clk/reset; spi_* flash pins (SCK = clk/2); addr_in/start_read/stall_read/stop_read
//        control; data_out/data_ready word output; busy while a transaction is open.
module qspi_flash_ctrl
  import qspi_flash_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 1,
  parameter int ADDR_BITS        = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    spi_data_in,
  output logic [3:0]                    spi_data_out,
  output logic [3:0]                    spi_data_oe,
  output logic                          spi_select,
  output logic                          spi_clk_out,
  input  logic [ADDR_BITS-1:0]          addr_in,
  input  logic                          start_read,
  input  logic                          stall_read,
  input  logic                          stop_read,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          data_ready,
  output logic                          busy
);

  localparam int WW    = 8 * DATA_WIDTH_BYTES;
  localparam int NIB_W = $clog2(2 * DATA_WIDTH_BYTES);
  localparam int POS_W = NIB_W + 2;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;       // SCK cycles done in current serial phase
  logic              sck_q, sck_d;
  logic              sel_q, sel_d;
  logic [3:0]        dout_q, dout_d;
  logic [3:0]        oe_q, oe_d;
  logic [31:0]       shift_q, shift_d;   // {opcode, address} shifted out MSB first
  logic [WW-1:0]     asm_q, asm_d;       // word under assembly
  logic [NIB_W-1:0]  nib_q, nib_d;       // nibbles received in current word
  logic              pend_q, pend_d;     // word complete, publish next cycle
  logic [WW-1:0]     data_q, data_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic [POS_W-1:0]  pos;

  // Nibble n lands at byte n/2; the first nibble of each byte is the high one.
  assign pos = {nib_q, 2'b00} ^ POS_W'(4);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sck_d   = sck_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    shift_d = shift_q;
    asm_d   = asm_q;
    nib_d   = nib_q;
    pend_d  = 1'b0;
    data_d  = data_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;

    if (pend_q) begin
      data_d = asm_q;
      rdy_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_read) begin
          state_d = CMD;
          sel_d   = 1'b0;
          busy_d  = 1'b1;
          oe_d    = 4'b0001;
          shift_d = {OPCODE_QOFR, 24'(addr_in)};
          dout_d  = {3'b000, OPCODE_QOFR[7]};
          cnt_d   = '0;
          nib_d   = '0;
          sck_d   = 1'b0;
        end
      end
      CMD, ADDR: begin
        sck_d = ~sck_q;
        if (sck_q) begin
          // Falling SCK: advance to the next serial bit.
          shift_d = shift_q << 1;
          dout_d  = {3'b000, shift_q[30]};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == phase_last(state_q)) begin
            cnt_d = '0;
            if (state_q == CMD) begin
              state_d = ADDR;
            end else begin
              state_d = DUMMY;
              oe_d    = 4'b0000;
              dout_d  = 4'b0000;
            end
          end
        end
      end
      DUMMY: begin
        sck_d = ~sck_q;
        if (sck_q) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == phase_last(DUMMY)) begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        sck_d = ~sck_q;
        if (sck_q) begin
          // Sample at the end of the SCK high phase.
          asm_d[pos +: 4] = spi_data_in;
          nib_d = nib_q + NIB_W'(1);
          if (nib_q == NIB_W'(2 * DATA_WIDTH_BYTES - 1)) begin
            nib_d  = '0;
            pend_d = 1'b1;
            if (stall_read) state_d = STALLED;
          end
        end
      end
      STALLED: begin
        sck_d = 1'b0;
        if (stall_read) begin
          rdy_d = 1'b1;
        end else begin
          // Resume with a rising edge straight away so the stream keeps its cadence.
          state_d = DATA;
          sck_d   = 1'b1;
        end
      end
      DESELECT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a simultaneous start or a pending word.
    if (busy_q && stop_read && (state_q != DESELECT)) begin
      state_d = DESELECT;
      sel_d   = 1'b1;
      sck_d   = 1'b0;
      oe_d    = 4'b0000;
      dout_d  = 4'b0000;
      pend_d  = 1'b0;
      rdy_d   = 1'b0;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      sel_q   <= 1'b1;
      dout_q  <= 4'b0000;
      oe_q    <= 4'b0000;
      shift_q <= '0;
      asm_q   <= '0;
      nib_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sck_q   <= sck_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      shift_q <= shift_d;
      asm_q   <= asm_d;
      nib_q   <= nib_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign spi_data_out = dout_q;
  assign spi_data_oe  = oe_q;
  assign spi_select   = sel_q;
  assign spi_clk_out  = sck_q;
  assign data_out     = data_q;
  assign data_ready   = rdy_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Scoreboard bench: two controllers (1-byte and 2-byte words) each attached to a small
// behavioural quad flash model; stimulus pushes expected commands/words into queues and
// independent monitors pop and compare when the flash sees a command or data_ready rises.
module tb_qspi_flash_ctrl;

  typedef struct {
    int          dut;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk, reset;
  int   cyc;
  int   n_chk, n_err;
  exp_t cmd_q[$];
  exp_t dat_q[$];

  logic        start_a [2];
  logic        stop_a  [2];
  logic        stall_a [2];
  logic [23:0] addr_a  [2];
  logic [3:0]  f_din   [2];

  logic [3:0]  dout0, oe0, dout1, oe1, din0, din1;
  logic        sel0, sck0, rdy0, busy0, sel1, sck1, rdy1, busy1;
  logic [7:0]  dat0;
  logic [15:0] dat1;

  logic [3:0]  dout_a [2];
  logic [3:0]  oe_a   [2];
  logic        sel_a  [2];
  logic        sck_a  [2];
  logic        rdy_a  [2];
  logic        busy_a [2];
  logic [15:0] dat_a  [2];

  assign din0 = f_din[0];
  assign din1 = f_din[1];
  assign dout_a[0] = dout0;  assign dout_a[1] = dout1;
  assign oe_a[0]   = oe0;    assign oe_a[1]   = oe1;
  assign sel_a[0]  = sel0;   assign sel_a[1]  = sel1;
  assign sck_a[0]  = sck0;   assign sck_a[1]  = sck1;
  assign rdy_a[0]  = rdy0;   assign rdy_a[1]  = rdy1;
  assign busy_a[0] = busy0;  assign busy_a[1] = busy1;
  assign dat_a[0]  = {8'h00, dat0};
  assign dat_a[1]  = dat1;

  qspi_flash_ctrl #(.DATA_WIDTH_BYTES(1), .ADDR_BITS(24)) u_dut0 (
    .clk(clk), .reset(reset), .spi_data_in(din0), .spi_data_out(dout0),
    .spi_data_oe(oe0), .spi_select(sel0), .spi_clk_out(sck0), .addr_in(addr_a[0]),
    .start_read(start_a[0]), .stall_read(stall_a[0]), .stop_read(stop_a[0]),
    .data_out(dat0), .data_ready(rdy0), .busy(busy0)
  );

  qspi_flash_ctrl #(.DATA_WIDTH_BYTES(2), .ADDR_BITS(24)) u_dut1 (
    .clk(clk), .reset(reset), .spi_data_in(din1), .spi_data_out(dout1),
    .spi_data_oe(oe1), .spi_select(sel1), .spi_clk_out(sck1), .addr_in(addr_a[1]),
    .start_read(start_a[1]), .stall_read(stall_a[1]), .stop_read(stop_a[1]),
    .data_out(dat1), .data_ready(rdy1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] fmem(input logic [23:0] a);
    case (a)
      24'h100000: return 8'hA5;
      24'h100001: return 8'h3C;
      24'h100010: return 8'h11;
      24'h100011: return 8'h22;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Flash model: shifts in IO0 on SCK rise for 32 bits, then after 8 dummy clocks
  // presents one nibble per SCK rise (high nibble first), stable until the next rise.
  initial begin
    int          fcnt [2];
    logic [31:0] fsh  [2];
    logic [23:0] faddr[2];
    logic        sck_prev[2];
    exp_t        e;
    int          n;
    logic [7:0]  b;
    for (int i = 0; i < 2; i++) begin
      fcnt[i] = 0; fsh[i] = '0; faddr[i] = '0; sck_prev[i] = 1'b0; f_din[i] = 4'h0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (sel_a[i]) begin
          fcnt[i] = 0;
        end else if (sck_a[i] && !sck_prev[i]) begin
          if (fcnt[i] < 32) begin
            fsh[i] = {fsh[i][30:0], dout_a[i][0]};
            if (fcnt[i] == 0) chk("cmd phase oe", 32'(oe_a[i]), 32'h1);
            if (fcnt[i] == 31) begin
              faddr[i] = fsh[i][23:0];
              if (cmd_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL unexpected command dut%0d: got %h expected none", i, fsh[i]);
              end else begin
                e = cmd_q.pop_front();
                chk("cmd dut", 32'(i), 32'(e.dut));
                chk("cmd word", fsh[i], e.val);
              end
            end
          end else if (fcnt[i] >= 40) begin
            n = fcnt[i] - 40;
            b = fmem(faddr[i] + 24'(n / 2));
            f_din[i] = ((n % 2) == 1) ? b[3:0] : b[7:4];
          end
          if (fcnt[i] == 36) chk("dummy phase oe", 32'(oe_a[i]), 32'h0);
          fcnt[i]++;
        end
        sck_prev[i] = sck_a[i];
      end
    end
  end

  // Data monitor: each rising data_ready pops one expected word and its arrival cycle.
  initial begin
    logic rdy_prev[2];
    exp_t e;
    rdy_prev[0] = 1'b0; rdy_prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset && rdy_a[i] && !rdy_prev[i]) begin
          if (dat_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected data_ready dut%0d: got %h expected none", i, dat_a[i]);
          end else begin
            e = dat_q.pop_front();
            chk("data dut", 32'(i), 32'(e.dut));
            chk("data word", 32'(dat_a[i]), e.val);
            chk("data cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        rdy_prev[i] = rdy_a[i];
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called just after a negedge; returns the cycle stamp of the accepting edge.
  task automatic do_start(input int d, input logic [23:0] a, output int t0);
    addr_a[d]  = a;
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    int t0;
    cyc = 0; n_chk = 0; n_err = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0; stop_a[i] = 1'b0; stall_a[i] = 1'b0; addr_a[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset select", 32'(sel0), 32'h1);
    chk("reset sck", 32'(sck0), 32'h0);
    chk("reset oe", 32'(oe0), 32'h0);
    chk("reset busy", 32'(busy0), 32'h0);
    chk("reset data_ready", 32'(rdy0), 32'h0);
    chk("reset dut1 all", {sel1, sck1, oe1, busy1, rdy1, dout1, dat1},
        {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0});
    reset = 1'b0;
    @(negedge clk);

    // Plain stream from 0x100000 with an ignored start mid-command, then stop.
    cmd_q.push_back('{0, 32'h6B100000, 0});
    do_start(0, 24'h100000, t0);
    dat_q.push_back('{0, 32'h0000_00A5, t0 + 85});
    dat_q.push_back('{0, 32'h0000_003C, t0 + 89});
    wait_until(t0 + 10);
    addr_a[0] = 24'h3FFFFF; start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    chk("busy during cmd", 32'(busy0), 32'h1);
    wait_until(t0 + 89);
    stop_a[0] = 1'b1;
    @(negedge clk);
    stop_a[0] = 1'b0;
    chk("stop deselect", {sel0, rdy0, sck0, oe0, busy0}, {1'b1, 1'b0, 1'b0, 4'h0, 1'b1});
    @(negedge clk);
    chk("busy after stop", 32'(busy0), 32'h0);

    // Restart at 0x100010, then simultaneous start+stop mid second byte.
    cmd_q.push_back('{0, 32'h6B100010, 0});
    do_start(0, 24'h100010, t0);
    dat_q.push_back('{0, 32'h0000_0011, t0 + 85});
    wait_until(t0 + 87);
    addr_a[0] = 24'h000123; start_a[0] = 1'b1; stop_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0; stop_a[0] = 1'b0;
    chk("start+stop deselect", {sel0, rdy0}, {1'b1, 1'b0});
    @(negedge clk);
    chk("start+stop idle", 32'(busy0), 32'h0);
    repeat (10) @(negedge clk);

    // Stall on the first byte for 20 cycles, release, expect next byte 4 cycles on.
    stall_a[0] = 1'b1;
    cmd_q.push_back('{0, 32'h6B100000, 0});
    do_start(0, 24'h100000, t0);
    dat_q.push_back('{0, 32'h0000_00A5, t0 + 85});
    wait_until(t0 + 85);
    for (int i = 0; i < 20; i++) begin
      chk("stall hold", {rdy0, sck0, sel0, dat0}, {1'b1, 1'b0, 1'b0, 8'hA5});
      @(negedge clk);
    end
    stall_a[0] = 1'b0;
    dat_q.push_back('{0, 32'h0000_003C, cyc + 5});
    @(negedge clk);
    chk("release drops ready", 32'(rdy0), 32'h0);
    wait_until(t0 + 111);
    stop_a[0] = 1'b1;
    @(negedge clk);
    stop_a[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Two-byte words on the second controller.
    cmd_q.push_back('{1, 32'h6B100010, 0});
    do_start(1, 24'h100010, t0);
    dat_q.push_back('{1, 32'h0000_2211, t0 + 89});
    wait_until(t0 + 90);
    stop_a[1] = 1'b1;
    @(negedge clk);
    stop_a[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("dut1 idle after stop", {busy1, sel1}, {1'b0, 1'b1});

    chk("cmd queue drained", 32'(cmd_q.size()), 32'h0);
    chk("data queue drained", 32'(dat_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
